// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU arbiter.
// Float field layout and FPU status width.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int DATA_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;
  localparam int STATUS_W = 4;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin priority encoder:
// first set request at or above ptr_i, with wrap.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    j     = 0;
    // Scan downward so the closest match to ptr_i wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sequencer sharing one strobeless FPU between N_REQ clients.
// Optional perf counters enabled by defining FPU_ARB_PERF_EN.
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int FPU_LATENCY = 4,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_op_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_op_b_i,
  output logic [DATA_W-1:0]       fpu_op_a_o,
  output logic [DATA_W-1:0]       fpu_op_b_o,
  input  logic [DATA_W-1:0]       fpu_data_i,
  input  logic [STATUS_W-1:0]     fpu_status_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic [STATUS_W-1:0]     rsp_status_o
`ifdef FPU_ARB_PERF_EN
  ,
  output logic [15:0]             perf_ops_o,
  output logic [15:0]             perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(FPU_LATENCY + 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STATUS_W-1:0] stat_q, stat_d;
  logic                vld_q, vld_d;
  logic [N_REQ-1:0]    rdy;
  logic [ID_W-1:0]     gnt;
  logic                any;
  int                  base;

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .idx_o(gnt),
    .any_o(any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    data_d  = data_q;
    stat_d  = stat_q;
    vld_d   = vld_q;
    rdy     = '0;
    base    = int'(gnt) * DATA_W;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          rdy[gnt] = 1'b1;
          op_a_d   = req_op_a_i[base +: DATA_W];
          op_b_d   = req_op_b_i[base +: DATA_W];
          id_d     = gnt;
          cnt_d    = CNT_W'(FPU_LATENCY);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d  = fpu_data_i;
          stat_d  = fpu_status_i;
          vld_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (vld_q && rsp_ready_i) begin
          vld_d   = 1'b0;
          ptr_d   = (id_q == ID_W'(N_REQ - 1)) ?
                    '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      data_q  <= '0;
      stat_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      data_q  <= data_d;
      stat_q  <= stat_d;
      vld_q   <= vld_d;
    end
  end

  assign req_ready_o  = rdy & {N_REQ{rst_ni}};
  assign fpu_op_a_o   = op_a_q;
  assign fpu_op_b_o   = op_b_q;
  assign rsp_valid_o  = vld_q;
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_status_o = stat_q;

`ifdef FPU_ARB_PERF_EN
  logic [15:0] ops_q;
  logic [15:0] stall_q;
  logic        acc;
  logic        stall;

  assign acc   = |rdy;
  assign stall = (|req_valid_i) && !(|rdy);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (acc && ops_q != 16'hFFFF) begin
        ops_q <= ops_q + 16'd1;
      end
      if (stall && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign perf_ops_o   = ops_q;
  assign perf_stall_o = stall_q;
`endif

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one FPU instance between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter latches the granted pair and holds it stable on the FPU operand inputs for FPU_LATENCY cycles, because the FPU has no start/done strobe. It then captures the FPU result and status and returns them on a single tagged response channel. It sits between the requesting datapath blocks and the FPU.

## Interface
- N_REQ, 4: number of requesters, 2..8
- FPU_LATENCY, 4: clock edges from operand change to a stable FPU `data_out`/`status_out`, ≥1
- ID_W (localparam), $clog2(N_REQ): requester tag width
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  one-hot accept strobe
- req_op_a  in  N_REQ*32  operand A; requester i occupies bits [32i+31:32i]
- req_op_b  in  N_REQ*32  operand B; same packing as req_op_a
- fpu_op_a  out  32  connects to FPU `op_A_in`
- fpu_op_b  out  32  connects to FPU `op_B_in`
- fpu_data  in  32  from FPU `data_out`
- fpu_status  in  4  from FPU `status_out`; opaque, passed through unchanged
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_data  out  32  captured FPU result
- rsp_status  out  4  captured FPU status

## Operation
- Operand format is opaque to this block: sign, 6-bit exponent (bias 31), 25-bit mantissa. For example, 1.0 = 0x3E000000 and 2.0 = 0x40000000.
- States are IDLE, WAIT and RESP.
- **IDLE**
  - If any req_valid is set, the winner g is the first set bit at or above `rr_ptr`, searching upward with wrap-around.
  - req_ready[g] is asserted combinationally in that same cycle.
  - On the clock edge: latch req_op_a/b[g] into fpu_op_a/b, latch g into rsp_id, load cnt = FPU_LATENCY, and move to WAIT.
  - req_ready is all-zero in WAIT and RESP.
- **WAIT**
  - cnt decrements each cycle.
  - On the edge where cnt==1: capture fpu_data into rsp_data and fpu_status into rsp_status, set rsp_valid, and move to RESP.
- **RESP**
  - All outputs hold.
  - When rsp_valid && rsp_ready: clear rsp_valid, set rr_ptr = (g+1) mod N_REQ, and return to IDLE.
- fpu_op_a/b change only on the IDLE accept edge. They remain stable through WAIT and RESP.
- A requester that deasserts req_valid before it is granted simply loses its turn. Requesters must hold req_valid and the operands stable until req_ready is seen.
- **Reset** (asynchronous assert, at any time including mid-WAIT or mid-RESP):
  - state=IDLE, rr_ptr=0, cnt=0
  - fpu_op_a/b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_status=0
  - req_ready is forced to 0 while reset is low
  - any in-flight operation is discarded with no response

## Timing
- Accept at edge T. fpu_op_a/b are valid from T. rsp_valid rises at edge T+FPU_LATENCY.
- Minimum occupancy per operation is FPU_LATENCY+2 cycles: accept, FPU_LATENCY WAIT edges, one RESP cycle with rsp_ready=1.
- rsp_ready held high causes no extra stall. IDLE can accept a new request on the cycle immediately after the RESP handshake edge.
- With all requesters valid continuously, grants rotate 0,1,2,…,N_REQ-1,0. No requester waits more than N_REQ-1 operations.

## Configuration
- **FPU_ARB_PERF_EN defined**: adds outputs perf_ops (16 bits) and perf_stall (16 bits). Both saturate at 0xFFFF and reset to 0.
  - perf_ops increments on each accept.
  - perf_stall increments on each cycle in which some req_valid bit is set but no req_ready bit is set.
- **FPU_ARB_PERF_EN undefined**: neither port nor the counters exist. Behaviour is otherwise identical.

## Structure
- Package fpu_arb_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - the float field constants: SIGN_BIT=31, EXP_W=6, MAN_W=25, EXP_BIAS=31
  - the FPU status width constant (4)
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector and rr_ptr.
  - Outputs: grant index and any-grant flag.

## Test plan
The bench uses a stub FPU that returns data = op_a ^ op_b and status = op_a[3:0] after FPU_LATENCY edges. N_REQ=4 and FPU_LATENCY=4.
- Single request: req0 sends A=0x3E000000, B=0x40000000 → req_ready[0] pulses for 1 cycle; rsp_valid rises exactly 4 edges after accept; rsp_id=0, rsp_data=0x7E000000, rsp_status=0x0.
- All four requesters valid continuously with rsp_ready=1 → grant order 0,1,2,3,0; each response carries the matching rsp_id and operand-derived data.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_data stay stable, req_ready stays 0, fpu_op_a/b stay unchanged; then rsp_ready=1 → return to IDLE in 1 cycle.
- Reset pulled low mid-WAIT (cnt=2) → all outputs 0 immediately; after release no response is issued; the next request from req2 is granted first with rr_ptr=0 rules.
- FPU_ARB_PERF_EN build, using the traffic of scenario 2 → perf_ops counts 5; perf_stall equals the number of WAIT/RESP cycles with pending requests.
